// File: rtl/sm_trace_buffer.sv
// sm_trace_buffer
//   Execution-trace capture for the schoolRISCV CPU. Records one entry
//   {cycle, pc, instr, data} per enabled CPU cycle into a DEPTH-entry buffer.
//   Capture stops on timeout, on a PC trigger, or when a one-shot buffer fills.
//   The buffer can be read back in any state, oldest entry first.
//
//   State table
//     state  | meaning
//     IDLE   | after reset, waiting for the first arm
//     RUN    | capturing one entry per sample_en
//     FROZEN | capture stopped by a stop condition, waiting for re-arm
//
// Ports
//   clk, rst_n      CPU clock, asynchronous active-low reset
//   sample_en       CPU advanced this cycle (captured only while RUN)
//   pc/instr/data   values captured into the entry
//   arm             pulse: clear and (re)start capture; wins over a same-cycle sample
//   circular        1 = ring buffer, 0 = one-shot (stop when full)
//   timeout_lim     freeze after the sample whose cycle equals this value (0 = off)
//   trig_en/trig_pc freeze after capturing the instruction at trig_pc
//   rd_addr         read index, 0 = oldest valid entry
//   rd_*            registered read data (1-cycle latency), zero past count
//   count           valid entries, saturating at DEPTH
//   running/frozen  state decode
//   timeout/trig_hit/full  sticky stop-cause flags, cleared by arm

module sm_trace_buffer #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32,
    parameter int DATA_W  = 32,
    parameter int CYC_W   = 16,
    parameter int DEPTH   = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sample_en,
    input  logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] instr,
    input  logic [DATA_W-1:0]  data,
    input  logic               arm,
    input  logic               circular,
    input  logic [CYC_W-1:0]   timeout_lim,
    input  logic               trig_en,
    input  logic [PC_W-1:0]    trig_pc,
    input  logic [AW-1:0]      rd_addr,
    output logic [CYC_W-1:0]   rd_cycle,
    output logic [PC_W-1:0]    rd_pc,
    output logic [INSTR_W-1:0] rd_instr,
    output logic [DATA_W-1:0]  rd_data,
    output logic [AW:0]        count,
    output logic               running,
    output logic               frozen,
    output logic               timeout,
    output logic               trig_hit,
    output logic               full
);

    localparam int ENTRY_W = CYC_W + PC_W + INSTR_W + DATA_W;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LAST_CNT = (AW+1)'(DEPTH - 1);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [CYC_W-1:0]   cycle;
    logic               wrapped;
    logic [AW-1:0]      phys;

    logic clear;
    logic do_write;
    logic hit_timeout;
    logic hit_trig;
    logic hit_full;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clear       = 1'b0;
        do_write    = 1'b0;
        hit_timeout = 1'b0;
        hit_trig    = 1'b0;
        hit_full    = 1'b0;
        if (arm) begin
            // arm beats a same-cycle sample: that sample is dropped
            clear     = 1'b1;
            state_nxt = RUN;
        end else if (state == RUN && sample_en) begin
            do_write    = 1'b1;
            hit_timeout = (timeout_lim != '0) && (cycle == timeout_lim);
            hit_trig    = trig_en && (pc == trig_pc);
            hit_full    = !circular && (count == LAST_CNT);
            if (hit_timeout || hit_trig || hit_full) begin
                state_nxt = FROZEN;
            end
        end
    end

    assign running = (state == RUN);
    assign frozen  = (state == FROZEN);

    // ---------------- capture bookkeeping ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            count    <= '0;
            cycle    <= '0;
            wrapped  <= 1'b0;
            timeout  <= 1'b0;
            trig_hit <= 1'b0;
            full     <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            count    <= '0;
            cycle    <= '0;
            wrapped  <= 1'b0;
            timeout  <= 1'b0;
            trig_hit <= 1'b0;
            full     <= 1'b0;
        end else if (do_write) begin
            wr_ptr <= wr_ptr + 1'b1;
            cycle  <= cycle + 1'b1;
            if (count != FULL_CNT) begin
                count <= count + 1'b1;
            end
            // once the ring has wrapped, wr_ptr always points at the oldest entry
            if (circular && wr_ptr == LAST_PTR) begin
                wrapped <= 1'b1;
            end
            timeout  <= timeout  | hit_timeout;
            trig_hit <= trig_hit | hit_trig;
            full     <= full     | hit_full;
        end
    end

    // Storage has no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= {cycle, pc, instr, data};
        end
    end

    // ---------------- read port ----------------
    // Logical index 0 is the oldest entry; the add wraps naturally mod DEPTH.
    always_comb begin
        phys = (wrapped ? wr_ptr : '0) + rd_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cycle <= '0;
            rd_pc    <= '0;
            rd_instr <= '0;
            rd_data  <= '0;
        end else if ({1'b0, rd_addr} < count) begin
            {rd_cycle, rd_pc, rd_instr, rd_data} <= mem[phys];
        end else begin
            rd_cycle <= '0;
            rd_pc    <= '0;
            rd_instr <= '0;
            rd_data  <= '0;
        end
    end

endmodule

// File: tb/tb_sm_trace_buffer.sv
// Testbench for sm_trace_buffer: directed scenarios plus a randomized run,
// all checked against a queue-based trace model.

module tb_sm_trace_buffer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    typedef struct packed {
        logic [15:0] cyc;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_en = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] instr = '0;
    logic [31:0] data = '0;
    logic        arm = 1'b0;
    logic        circular = 1'b0;
    logic [15:0] timeout_lim = '0;
    logic        trig_en = 1'b0;
    logic [31:0] trig_pc = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [15:0] rd_cycle;
    logic [31:0] rd_pc;
    logic [31:0] rd_instr;
    logic [31:0] rd_data;
    logic [AW:0] count;
    logic        running;
    logic        frozen;
    logic        timeout;
    logic        trig_hit;
    logic        full;

    int checks = 0;
    int errors = 0;

    sm_trace_buffer #(
        .PC_W(32), .INSTR_W(32), .DATA_W(32), .CYC_W(16), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .pc(pc), .instr(instr),
        .data(data), .arm(arm), .circular(circular), .timeout_lim(timeout_lim),
        .trig_en(trig_en), .trig_pc(trig_pc), .rd_addr(rd_addr),
        .rd_cycle(rd_cycle), .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_data(rd_data),
        .count(count), .running(running), .frozen(frozen), .timeout(timeout),
        .trig_hit(trig_hit), .full(full)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // m_state: 0 idle, 1 capturing, 2 stopped
    ent_t        mq[$];
    int          m_state = 0;
    logic [15:0] m_cyc = '0;
    bit          m_timeout = 0, m_trig = 0, m_full = 0;
    ent_t        exp_rd = '0;

    task automatic model_reset();
        mq.delete();
        m_state = 0;
        m_cyc = '0;
        m_timeout = 0; m_trig = 0; m_full = 0;
        exp_rd = '0;
    endtask

    // One clock: the read expectation comes from the trace as it stood before the edge.
    task automatic step();
        bit t, g, f;
        exp_rd = (int'(rd_addr) < mq.size()) ? mq[rd_addr] : '0;
        @(posedge clk);
        if (arm) begin
            mq.delete();
            m_cyc = '0;
            m_timeout = 0; m_trig = 0; m_full = 0;
            m_state = 1;
        end else if (m_state == 1 && sample_en) begin
            t = (timeout_lim != 0) && (m_cyc == timeout_lim);
            g = trig_en && (pc == trig_pc);
            f = !circular && (mq.size() == DEPTH - 1);
            mq.push_back('{cyc: m_cyc, pc: pc, instr: instr, data: data});
            if (mq.size() > DEPTH) void'(mq.pop_front());
            m_cyc = m_cyc + 16'd1;
            m_timeout |= t; m_trig |= g; m_full |= f;
            if (t || g || f) m_state = 2;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_sample(input int i);
        sample_en = 1'b1;
        pc    = 32'(i * 4);
        instr = $urandom;
        data  = $urandom;
    endtask

    task automatic do_arm();
        arm = 1'b1; sample_en = 1'b0;
        step();
        arm = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #3;
        checks++;
        if (count !== 0 || running !== 0 || frozen !== 0 || timeout !== 0 ||
            trig_hit !== 0 || full !== 0) begin
            errors++;
            $display("FAIL reset_state: count=%0d run=%0b frz=%0b to=%0b tr=%0b full=%0b, expected all 0",
                     count, running, frozen, timeout, trig_hit, full);
        end
        checks++;
        if ({rd_cycle, rd_pc, rd_instr, rd_data} !== '0) begin
            errors++;
            $display("FAIL reset_rd: rd=%h expected 0", {rd_cycle, rd_pc, rd_instr, rd_data});
        end
        #9;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        circular = 0; timeout_lim = 0; trig_en = 0;
        do_arm();
        for (int i = 0; i < 5; i++) begin drive_sample(i); step(); end
        sample_en = 0;
        checks++;
        if (count !== 5 || running !== 1) begin
            errors++;
            $display("FAIL basic_count: count=%0d running=%0b expected 5 1", count, running);
        end
        rd_addr = 2; step();
        checks++;
        if (rd_pc !== 32'd8 || rd_cycle !== 16'd2 || rd_data !== exp_rd.data) begin
            errors++;
            $display("FAIL basic_read: pc=%0d cyc=%0d data=%h expected 8 2 %h",
                     rd_pc, rd_cycle, rd_data, exp_rd.data);
        end
    endtask

    task automatic test_oneshot_full();
        circular = 0; timeout_lim = 0; trig_en = 0;
        do_arm();
        for (int i = 0; i < 20; i++) begin drive_sample(i); step(); end
        sample_en = 0;
        checks++;
        if (full !== 1 || frozen !== 1 || count !== 16 || timeout !== 0) begin
            errors++;
            $display("FAIL oneshot_flags: full=%0b frozen=%0b count=%0d to=%0b expected 1 1 16 0",
                     full, frozen, count, timeout);
        end
        rd_addr = 15; step();
        checks++;
        if (rd_cycle !== 16'd15 || rd_pc !== 32'd60 || rd_instr !== exp_rd.instr) begin
            errors++;
            $display("FAIL oneshot_last: cyc=%0d pc=%0d instr=%h expected 15 60 %h",
                     rd_cycle, rd_pc, rd_instr, exp_rd.instr);
        end
    endtask

    task automatic test_circular();
        circular = 1; timeout_lim = 0; trig_en = 0;
        do_arm();
        for (int i = 0; i < 20; i++) begin drive_sample(i); step(); end
        sample_en = 0;
        checks++;
        if (count !== 16 || running !== 1 || full !== 0) begin
            errors++;
            $display("FAIL circ_count: count=%0d running=%0b full=%0b expected 16 1 0",
                     count, running, full);
        end
        rd_addr = 0; step();
        checks++;
        if (rd_cycle !== 16'd4 || rd_pc !== 32'd16) begin
            errors++;
            $display("FAIL circ_oldest: cyc=%0d pc=%0d expected 4 16", rd_cycle, rd_pc);
        end
        rd_addr = 15; step();
        checks++;
        if (rd_cycle !== 16'd19 || rd_pc !== 32'd76) begin
            errors++;
            $display("FAIL circ_newest: cyc=%0d pc=%0d expected 19 76", rd_cycle, rd_pc);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        circular = 1; timeout_lim = 16'd120; trig_en = 0;
        do_arm();
        while (!frozen && n < 300) begin drive_sample(n); step(); n++; end
        checks++;
        if (n !== 121) begin
            errors++;
            $display("FAIL timeout_len: samples_to_freeze=%0d expected 121", n);
        end
        for (int i = 0; i < 3; i++) begin drive_sample(500 + i); step(); end
        sample_en = 0;
        checks++;
        if (timeout !== 1 || frozen !== 1 || count !== 16 || trig_hit !== 0) begin
            errors++;
            $display("FAIL timeout_flags: to=%0b frozen=%0b count=%0d tr=%0b expected 1 1 16 0",
                     timeout, frozen, count, trig_hit);
        end
        rd_addr = 15; step();
        checks++;
        if (rd_cycle !== 16'd120 || rd_pc !== 32'd480) begin
            errors++;
            $display("FAIL timeout_last: cyc=%0d pc=%0d expected 120 480", rd_cycle, rd_pc);
        end
        timeout_lim = 0;
    endtask

    task automatic test_trigger();
        circular = 0; timeout_lim = 0; trig_en = 1; trig_pc = 32'h0c;
        do_arm();
        for (int i = 0; i < 8; i++) begin drive_sample(i); step(); end
        sample_en = 0;
        checks++;
        if (trig_hit !== 1 || count !== 4 || timeout !== 0 || frozen !== 1) begin
            errors++;
            $display("FAIL trig_only: tr=%0b count=%0d to=%0b frozen=%0b expected 1 4 0 1",
                     trig_hit, count, timeout, frozen);
        end
        timeout_lim = 16'd3;
        do_arm();
        for (int i = 0; i < 8; i++) begin drive_sample(i); step(); end
        sample_en = 0;
        checks++;
        if (trig_hit !== 1 || timeout !== 1 || count !== 4 || full !== 0) begin
            errors++;
            $display("FAIL trig_and_timeout: tr=%0b to=%0b count=%0d full=%0b expected 1 1 4 0",
                     trig_hit, timeout, count, full);
        end
        trig_en = 0; timeout_lim = 0;
    endtask

    task automatic test_arm_and_reset();
        circular = 0; timeout_lim = 0; trig_en = 0;
        do_arm();
        for (int i = 0; i < 3; i++) begin drive_sample(i + 1); step(); end
        arm = 1; drive_sample(9); step();
        arm = 0; sample_en = 0;
        checks++;
        if (count !== 0 || running !== 1) begin
            errors++;
            $display("FAIL arm_drop: count=%0d running=%0b expected 0 1", count, running);
        end
        for (int i = 0; i < 2; i++) begin drive_sample(i + 1); step(); end
        sample_en = 0;
        rd_addr = 1; step();
        checks++;
        if (rd_pc !== 32'd8 || rd_cycle !== 16'd1 || rd_data !== exp_rd.data) begin
            errors++;
            $display("FAIL arm_restart_read: pc=%0d cyc=%0d data=%h expected 8 1 %h",
                     rd_pc, rd_cycle, rd_data, exp_rd.data);
        end
        drive_sample(7);
        rst_n = 1'b0;
        model_reset();
        #2;
        checks++;
        if (running !== 0 || count !== 0 || rd_pc !== 0 || rd_cycle !== 0 || rd_data !== 0) begin
            errors++;
            $display("FAIL reset_midrun: run=%0b count=%0d rd_pc=%0d rd_cyc=%0d rd_data=%h expected 0",
                     running, count, rd_pc, rd_cycle, rd_data);
        end
        sample_en = 0;
        #10;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            arm = (n == 0) || ($urandom_range(0, 59) == 0);
            if (arm) begin
                circular    = $urandom_range(0, 1);
                timeout_lim = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(5, 40)) : 16'd0;
                trig_en     = ($urandom_range(0, 3) == 0);
                trig_pc     = 32'($urandom_range(0, 31) * 4);
            end
            sample_en = ($urandom_range(0, 3) != 0);
            pc        = 32'($urandom_range(0, 31) * 4);
            instr     = $urandom;
            data      = $urandom;
            rd_addr   = AW'($urandom_range(0, DEPTH - 1));
            step();
            checks++;
            if ({rd_cycle, rd_pc, rd_instr, rd_data} !== exp_rd) begin
                errors++;
                $display("FAIL rand_read n=%0d: got %h expected %h",
                         n, {rd_cycle, rd_pc, rd_instr, rd_data}, exp_rd);
            end
            checks++;
            if (count !== (AW+1)'(mq.size()) || running !== (m_state == 1) ||
                frozen !== (m_state == 2)) begin
                errors++;
                $display("FAIL rand_state n=%0d: count=%0d run=%0b frz=%0b expected %0d %0b %0b",
                         n, count, running, frozen, mq.size(), m_state == 1, m_state == 2);
            end
            checks++;
            if (timeout !== m_timeout || trig_hit !== m_trig || full !== m_full) begin
                errors++;
                $display("FAIL rand_flags n=%0d: to=%0b tr=%0b full=%0b expected %0b %0b %0b",
                         n, timeout, trig_hit, full, m_timeout, m_trig, m_full);
            end
        end
        arm = 0; sample_en = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_oneshot_full();
        test_circular();
        test_timeout();
        test_trigger();
        test_arm_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
